// File: rtl/au_gray_cnt_if.sv
// Command/status bundle for the up/down Gray-code counter.
// The master issues clear/load/count commands; the slave returns the Gray and binary counts.
interface au_gray_cnt_if #(
    parameter int WIDTH = 8
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] ld_val;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] b;
    logic             wrap;

    modport master (
        output clr,
        output load,
        output ld_val,
        output en,
        output up,
        input  g,
        input  b,
        input  wrap
    );

    modport slave (
        input  clr,
        input  load,
        input  ld_val,
        input  en,
        input  up,
        output g,
        output b,
        output wrap
    );
endinterface

// File: rtl/au_gray_cnt.sv
// Registered up/down Gray-code counter with a matching binary count and a wrap-around pulse.
// The Gray word has its own register, loaded from the Gray encoding of the next binary value.
module au_gray_cnt #(
    parameter int          WIDTH = 8,
    parameter int unsigned INIT  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    au_gray_cnt_if.slave cnt
);

    localparam logic [WIDTH-1:0] INIT_B = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] INIT_G = INIT_B ^ (INIT_B >> 1);
    localparam logic [WIDTH-1:0] ONES   = '1;
    localparam logic [WIDTH-1:0] ZERO   = '0;
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] g_q;
    logic             wrap_q;

    logic [WIDTH-1:0] next_b;
    logic [WIDTH-1:0] next_g;
    logic             next_wrap;

    // Clear beats load beats counting; wrap only comes from a counting step across the end.
    always_comb begin
        next_b    = b_q;
        next_wrap = 1'b0;
        if (cnt.clr) begin
            next_b = INIT_B;
        end else if (cnt.load) begin
            next_b = cnt.ld_val;
        end else if (cnt.en) begin
            if (cnt.up) begin
                next_b    = b_q + ONE;
                next_wrap = (b_q == ONES);
            end else begin
                next_b    = b_q - ONE;
                next_wrap = (b_q == ZERO);
            end
        end
    end

    assign next_g = next_b ^ (next_b >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q    <= INIT_B;
            g_q    <= INIT_G;
            wrap_q <= 1'b0;
        end else begin
            b_q    <= next_b;
            g_q    <= next_g;
            wrap_q <= next_wrap;
        end
    end

    assign cnt.b    = b_q;
    assign cnt.g    = g_q;
    assign cnt.wrap = wrap_q;

endmodule

// File: tb/tb_au_gray_cnt.sv
// Directed bench for au_gray_cnt: reset, sweep, wrap, priority, async reset and a modelled random run.
module tb_au_gray_cnt;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    au_gray_cnt_if #(.WIDTH(4)) if5 ();
    au_gray_cnt_if #(.WIDTH(4)) if0 ();
    au_gray_cnt_if #(.WIDTH(1)) if1 ();
    au_gray_cnt_if #(.WIDTH(8)) if8 ();

    au_gray_cnt #(.WIDTH(4), .INIT(5))   u_dut5 (.clk(clk), .rst_n(rst_n), .cnt(if5));
    au_gray_cnt #(.WIDTH(4), .INIT(0))   u_dut0 (.clk(clk), .rst_n(rst_n), .cnt(if0));
    au_gray_cnt #(.WIDTH(1), .INIT(0))   u_dut1 (.clk(clk), .rst_n(rst_n), .cnt(if1));
    au_gray_cnt #(.WIDTH(8), .INIT(165)) u_dut8 (.clk(clk), .rst_n(rst_n), .cnt(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge so outputs are sampled away from it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gray2bin8(input logic [7:0] gv);
        logic [7:0] r;
        r[7] = gv[7];
        for (int i = 6; i >= 0; i--) r[i] = r[i+1] ^ gv[i];
        return r;
    endfunction

    logic [3:0] gtab [16];
    logic [3:0] prev_g;
    logic [7:0] prev_g8;
    logic [7:0] mb;
    logic       mwrap;
    logic       only_en;
    logic       r_clr, r_load, r_en, r_up;
    logic [7:0] r_ld;

    initial begin
        errors = 0;
        checks = 0;
        gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        {if5.clr, if5.load, if5.en, if5.up, if5.ld_val} = '0;
        {if0.clr, if0.load, if0.en, if0.up, if0.ld_val} = '0;
        {if1.clr, if1.load, if1.en, if1.up, if1.ld_val} = '0;
        {if8.clr, if8.load, if8.en, if8.up, if8.ld_val} = '0;

        // Reset asserted before any clock edge
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        checkOutput("reset_b5", 16'(if5.b), 16'h5);
        checkOutput("reset_g5", 16'(if5.g), 16'h7);
        checkOutput("reset_wrap5", 16'(if5.wrap), 16'h0);
        checkOutput("reset_b0", 16'(if0.b), 16'h0);
        checkOutput("reset_g8", 16'(if8.g), 16'hF7);
        checkOutput("reset_b8", 16'(if8.b), 16'hA5);
        #3 rst_n = 1'b1;

        repeat (3) applyStimulus();
        checkOutput("hold_b5", 16'(if5.b), 16'h5);
        checkOutput("hold_g5", 16'(if5.g), 16'h7);
        checkOutput("hold_wrap5", 16'(if5.wrap), 16'h0);

        // Full up sweep on the INIT=0 counter, WIDTH=1 counter toggling alongside
        if0.en = 1'b1; if0.up = 1'b1;
        if1.en = 1'b1; if1.up = 1'b1;
        prev_g = if0.g;
        for (int k = 1; k <= 17; k++) begin
            applyStimulus();
            checkOutput($sformatf("sweep_g%0d", k), 16'(if0.g), 16'(gtab[k % 16]));
            checkOutput($sformatf("sweep_b%0d", k), 16'(if0.b), 16'(k % 16));
            checkOutput($sformatf("sweep_wrap%0d", k), 16'(if0.wrap), 16'((k % 16) == 0));
            checkOutput($sformatf("sweep_onebit%0d", k), 16'($countones(if0.g ^ prev_g)), 16'd1);
            prev_g = if0.g;
            checkOutput($sformatf("w1_b%0d", k), 16'(if1.b), 16'(k % 2));
            checkOutput($sformatf("w1_g%0d", k), 16'(if1.g), 16'(k % 2));
            checkOutput($sformatf("w1_wrap%0d", k), 16'(if1.wrap), 16'((k % 2) == 0));
        end
        if1.en = 1'b0;

        // Load 1, count down through zero to all-ones, then reverse
        if0.en = 1'b0; if0.load = 1'b1; if0.ld_val = 4'h1;
        applyStimulus();
        checkOutput("dn_load_b", 16'(if0.b), 16'h1);
        if0.load = 1'b0; if0.en = 1'b1; if0.up = 1'b0;
        applyStimulus();
        checkOutput("dn_b0", 16'(if0.b), 16'h0);
        checkOutput("dn_wrap0", 16'(if0.wrap), 16'h0);
        applyStimulus();
        checkOutput("dn_bF", 16'(if0.b), 16'hF);
        checkOutput("dn_gF", 16'(if0.g), 16'h8);
        checkOutput("dn_wrapF", 16'(if0.wrap), 16'h1);
        if0.up = 1'b1;
        applyStimulus();
        checkOutput("rev_b", 16'(if0.b), 16'h0);
        checkOutput("rev_g", 16'(if0.g), 16'h0);
        checkOutput("rev_wrap", 16'(if0.wrap), 16'h1);
        if0.en = 1'b0;

        // Priority and load behaviour on the INIT=5 counter
        if5.en = 1'b1; if5.up = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("pri_pre_b", 16'(if5.b), 16'h7);
        checkOutput("pri_pre_g", 16'(if5.g), 16'h4);
        if5.clr = 1'b1; if5.load = 1'b1; if5.ld_val = 4'h9;
        applyStimulus();
        checkOutput("pri_clr_b", 16'(if5.b), 16'h5);
        checkOutput("pri_clr_g", 16'(if5.g), 16'h7);
        checkOutput("pri_clr_wrap", 16'(if5.wrap), 16'h0);
        if5.clr = 1'b0; if5.ld_val = 4'hF;
        applyStimulus();
        checkOutput("pri_ld_b", 16'(if5.b), 16'hF);
        checkOutput("pri_ld_g", 16'(if5.g), 16'h8);
        checkOutput("pri_ld_wrap", 16'(if5.wrap), 16'h0);
        if5.load = 1'b0;
        applyStimulus();
        checkOutput("pri_up_b", 16'(if5.b), 16'h0);
        checkOutput("pri_up_wrap", 16'(if5.wrap), 16'h1);
        if5.en = 1'b0; if5.load = 1'b1; if5.ld_val = 4'hF;
        applyStimulus();
        checkOutput("ldF_wrap", 16'(if5.wrap), 16'h0);
        if5.ld_val = 4'h0;
        applyStimulus();
        checkOutput("ld0_b", 16'(if5.b), 16'h0);
        checkOutput("ld0_wrap", 16'(if5.wrap), 16'h0);
        if5.load = 1'b0;

        // Count to 7, then drop reset between edges
        if0.clr = 1'b1;
        applyStimulus();
        if0.clr = 1'b0; if0.en = 1'b1; if0.up = 1'b1;
        repeat (7) applyStimulus();
        checkOutput("mid_b7", 16'(if0.b), 16'h7);
        checkOutput("mid_g7", 16'(if0.g), 16'h4);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_b0", 16'(if0.b), 16'h0);
        checkOutput("arst_g0", 16'(if0.g), 16'h0);
        checkOutput("arst_wrap0", 16'(if0.wrap), 16'h0);
        checkOutput("arst_b5", 16'(if5.b), 16'h5);
        checkOutput("arst_g5", 16'(if5.g), 16'h7);
        #1 rst_n = 1'b1;
        applyStimulus();
        checkOutput("post_arst_b", 16'(if0.b), 16'h1);
        checkOutput("post_arst_g", 16'(if0.g), 16'h1);
        if0.en = 1'b0;

        // Random commands on the WIDTH=8 counter against a reference model
        mb = 8'hA5;
        mwrap = 1'b0;
        prev_g8 = if8.g;
        checkOutput("rnd_start_b", 16'(if8.b), 16'(mb));
        for (int n = 0; n < 300; n++) begin
            r_clr  = ($urandom_range(0, 29) == 0);
            r_load = ($urandom_range(0, 14) == 0);
            r_en   = ($urandom_range(0, 3) != 0);
            r_up   = ($urandom_range(0, 1) == 1);
            r_ld   = 8'($urandom_range(0, 255));
            if (n % 50 == 10) begin
                r_clr = 1'b0; r_load = 1'b1; r_ld = 8'hFF;
            end
            if8.clr = r_clr; if8.load = r_load; if8.en = r_en; if8.up = r_up; if8.ld_val = r_ld;
            only_en = !r_clr && !r_load && r_en;
            if (r_clr) begin
                mb = 8'hA5; mwrap = 1'b0;
            end else if (r_load) begin
                mb = r_ld; mwrap = 1'b0;
            end else if (r_en && r_up) begin
                mwrap = (mb == 8'hFF); mb = mb + 8'd1;
            end else if (r_en) begin
                mwrap = (mb == 8'h00); mb = mb - 8'd1;
            end else begin
                mwrap = 1'b0;
            end
            applyStimulus();
            checkOutput($sformatf("rnd_b%0d", n), 16'(if8.b), 16'(mb));
            checkOutput($sformatf("rnd_conv%0d", n), 16'(gray2bin8(if8.g)), 16'(mb));
            checkOutput($sformatf("rnd_wrap%0d", n), 16'(if8.wrap), 16'(mwrap));
            if (only_en)
                checkOutput($sformatf("rnd_onebit%0d", n), 16'($countones(if8.g ^ prev_g8)), 16'd1);
            prev_g8 = if8.g;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/au_gray_cnt.md
Name: au_gray_cnt

Overview:
- Registered up/down Gray-code counter; the stage directly upstream of the Gray-to-binary converter (AU_gray2bin).
- Produces a single-bit-change Gray sequence (e.g. FIFO pointers, position codes) plus the matching binary value for local use.
- Downstream converter output on `g` must equal this block's `b` output in the same cycle. This is a self-check invariant for verification.

Parameters:
- WIDTH, 8, counter word length (>= 1).
- INIT, 0, binary reset/clear value; only bits [WIDTH-1:0] are used.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear to INIT.
- load  input  1  synchronous load of ld_val.
- ld_val  input  WIDTH  binary load value.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- g  output  WIDTH  registered Gray count.
- b  output  WIDTH  registered binary count.
- wrap  output  1  registered one-cycle wrap-around pulse.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-safe deassert by the user):
  - b = INIT[WIDTH-1:0]
  - g = INIT ^ (INIT >> 1), truncated to WIDTH
  - wrap = 0
- Next state is selected in strict priority order each rising edge:
  - clr: b <= INIT, wrap <= 0.
  - else load: b <= ld_val, wrap <= 0.
  - else en && up: b <= b + 1 mod 2^WIDTH.
  - else en && !up: b <= b - 1 mod 2^WIDTH.
  - else hold; wrap <= 0.
- g is held in its own register and is loaded with bin2gray(next b), i.e. next_b ^ (next_b >> 1). It is never derived combinationally from the b register.
- Invariant every cycle: g == b ^ (b >> 1).
- Latency: b and g reflect a command on the first rising edge after it is sampled (1 cycle). Both outputs change in the same cycle.
- While counting, consecutive g values differ in exactly one bit. This includes wrap-around and direction reversal.
  - Load and clear may change any number of bits.
- wrap is asserted for exactly the cycle in which b shows the wrapped value:
  - up: all-ones -> 0.
  - down: 0 -> all-ones.
  - wrap is 0 in all other cycles, including a load of 0 or all-ones.
- Back-to-back wraps are legal. With WIDTH=1 and en held, wrap pulses on alternate cycles: up = 1->0; down = 0->1.
- Direction change takes effect on the same edge it is sampled. There is no pipeline bubble.
- WIDTH=1: g == b always. The counter toggles when en=1.
- Reset mid-count: outputs return to their reset values immediately (asynchronously). The first count after release starts from INIT.
- No X propagation: all registers are reset. Inputs are assumed synchronous to clk.

Test Plan:
- Reset and hold:
  - WIDTH=4, INIT=5; assert rst_n=0.
  - Required: b=4'h5, g=4'h7, wrap=0.
  - Release with en=0 for 3 cycles; outputs unchanged.
- Full up sweep:
  - WIDTH=4, INIT=0, en=1, up=1 for 17 cycles.
  - Required: g follows 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - Exactly one bit changes per step. wrap=1 only in the cycle when b returns to 0.
- Down wrap and reversal:
  - Load 4'h1, then en=1, up=0 for 2 cycles -> b=0, then b=F with wrap=1, g=8.
  - Next cycle up=1 -> b=0, g=0, wrap=1.
- Priority:
  - Same cycle clr=1, load=1, ld_val=9, en=1 -> b=INIT, wrap=0.
  - Next cycle load=1, en=1, ld_val=F -> b=F, g=8, wrap=0.
- Converter cross-check:
  - Random en/up/load for 2000 cycles, WIDTH in {1,8,13}; feed g into AU_gray2bin (ARCH 0..2).
  - Required: converter output == b every cycle; popcount(g ^ g_prev) <= 1 whenever the previous cycle had only en set.
- Async reset mid-count:
  - Drop rst_n between clock edges at b=7.
  - Required: b=INIT, g=bin2gray(INIT), wrap=0 immediately, with no clock edge needed.
